pc_unit: RTL and testbench

Parametrised program-counter unit for the C0 core. It replaces the fixed 8-bit instruction pointer with an AW-bit PC and flag-conditioned jumps, and adds conditional CALL, unconditional RET through a DEPTH-entry return-address stack, a stall input, and sticky stack-error flags. Every register updates on the rising edge of CLK only; there is no inverted or derived clock. The unit sits between the instruction decoder/FLAGS register and instruction memory address.

---
 rtl/c0_pkg.sv | 27 ++
 rtl/pc_unit_ret_stack.sv | 54 +++++
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c0_pkg.sv
// Shared C0 core definitions: default address width, flag indices and a
// constant-friendly ceil(log2) helper.
package c0_pkg;

  localparam int C0_AW_DEFAULT = 8;

  typedef enum logic [2:0] {
    FLG_Z = 3'd0,
    FLG_1 = 3'd1,
    FLG_2 = 3'd2,
    FLG_3 = 3'd3,
    FLG_4 = 3'd4,
    FLG_5 = 3'd5,
    FLG_6 = 3'd6,
    FLG_7 = 3'd7
  } flag_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO: DEPTH entries of AW bits, combinational top-of-stack.
// Push into a full stack and pop from an empty one are ignored.
module ret_stack
  import c0_pkg::*;
#(
  parameter int AW    = C0_AW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AW-1:0]        din,
  output logic [AW-1:0]        dout,
  output logic [clog2(DEPTH):0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int IW = clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [AW-1:0] mem_reg [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_idx = count_reg[IW-1:0];
  assign rd_idx = wr_idx - IW'(1);
  assign full   = (count_reg == CW'(DEPTH));
  assign empty  = (count_reg == '0);
  assign count  = count_reg;
  assign dout   = mem_reg[rd_idx];

  always_comb begin
    count_next = count_reg;
    if (push && !full)       count_next = count_reg + CW'(1);
    else if (pop && !empty)  count_next = count_reg - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) count_reg <= '0;
    else        count_reg <= count_next;
  end

  // Contents are left unreset; only the pointer defines validity.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge CLK) begin
      if (push && !full && wr_idx == IW'(gi)) mem_reg[gi] <= din;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter for the C0 core: flag-conditioned JMP/CALL, RET through a
// return stack, stall hold and sticky stack-error flags.
module pc_unit
  import c0_pkg::*;
#(
  parameter int            AW        = C0_AW_DEFAULT,
  parameter int            DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  STALL,
  input  logic                  JMP_INST,
  input  logic                  CALL_INST,
  input  logic                  RET_INST,
  input  logic [3:0]            OP,
  input  logic [7:0]            FLAGS,
  input  logic [AW-1:0]         TARGET,
  output logic [AW-1:0]         ADDR,
  output logic [clog2(DEPTH):0] SP,
  output logic                  STK_OVF,
  output logic                  STK_UNF
);

  logic [AW-1:0] addr_reg, addr_next, addr_inc;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;
  logic          push, pop;
  logic [AW-1:0] stk_top;
  logic          stk_full, stk_empty;
  logic          cond;
  flag_e         flag_sel;

  assign flag_sel = flag_e'(OP[2:0]);
  assign cond     = (FLAGS[flag_sel] == OP[3]);
  assign addr_inc = addr_reg + AW'(1);

  ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .dout  (stk_top),
    .count (SP),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Priority RET > CALL > JMP; a failed stack op falls through to PC+1.
  always_comb begin
    addr_next = addr_inc;
    ovf_next  = ovf_reg;
    unf_next  = unf_reg;
    push      = 1'b0;
    pop       = 1'b0;
    if (STALL) begin
      addr_next = addr_reg;
    end else if (RET_INST) begin
      if (!stk_empty) begin
        pop       = 1'b1;
        addr_next = stk_top;
      end else begin
        unf_next  = 1'b1;
      end
    end else if (CALL_INST) begin
      if (cond) begin
        if (!stk_full) begin
          push      = 1'b1;
          addr_next = TARGET;
        end else begin
          ovf_next  = 1'b1;
        end
      end
    end else if (JMP_INST && cond) begin
      addr_next = TARGET;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr_reg <= RESET_VEC;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
    end else begin
      addr_reg <= addr_next;
      ovf_reg  <= ovf_next;
      unf_reg  <= unf_next;
    end
  end

  assign ADDR    = addr_reg;
  assign STK_OVF = ovf_reg;
  assign STK_UNF = unf_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Scenario tests plus a randomized run of pc_unit against a queue-based
// model of the program counter and return stack.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, jmp, call, ret;
  logic [3:0] op;
  logic [7:0] flags;
  logic [7:0] target;
  logic [7:0] addr;
  logic [2:0] sp;
  logic       ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_addr;
  logic [7:0] m_stack[$];
  logic       m_ovf, m_unf;

  pc_unit #(.AW(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .STALL     (stall),
    .JMP_INST  (jmp),
    .CALL_INST (call),
    .RET_INST  (ret),
    .OP        (op),
    .FLAGS     (flags),
    .TARGET    (target),
    .ADDR      (addr),
    .SP        (sp),
    .STK_OVF   (ovf),
    .STK_UNF   (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step();
    bit c;
    c = (((flags >> op[2:0]) & 8'd1) == {7'd0, op[3]});
    if (!rst_n) begin
      m_addr = 8'h00;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (stall) begin
      // hold
    end else if (ret) begin
      if (m_stack.size() > 0) m_addr = m_stack.pop_back();
      else begin m_addr = m_addr + 8'd1; m_unf = 1'b1; end
    end else if (call && c) begin
      if (m_stack.size() < 4) begin
        m_stack.push_back(m_addr + 8'd1);
        m_addr = target;
      end else begin
        m_addr = m_addr + 8'd1;
        m_ovf  = 1'b1;
      end
    end else if (jmp && c) begin
      m_addr = target;
    end else begin
      m_addr = m_addr + 8'd1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%b st=%b r/c/j=%b%b%b addr=%02h sp=%0d ovf=%b unf=%b",
             $time, rst_n, stall, ret, call, jmp, addr, sp, ovf, unf);
  endtask

  task automatic idle();
    stall = 0; jmp = 0; call = 0; ret = 0;
  endtask

  task automatic do_reset(input int cycles);
    idle();
    rst_n = 0;
    repeat (cycles) tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++;
    if (addr !== 8'h00 || sp !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: addr=%02h sp=%0d ovf=%b unf=%b want 00/0/0/0", addr, sp, ovf, unf);
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_checks++;
      if (addr !== 8'(i) || sp !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
        n_fail++;
        $display("FAIL increment: addr=%02h sp=%0d want %02h sp=0", addr, sp, 8'(i));
      end
    end
  endtask

  task automatic test_jump();
    logic [7:0] prev;
    flags = 8'b0000_0001; op = 4'b1000; target = 8'h40; jmp = 1;
    tick();
    n_checks++;
    if (addr !== 8'h40) begin
      n_fail++;
      $display("FAIL jmp_taken: addr=%02h want 40", addr);
    end
    prev = 8'h40;
    op = 4'b0000;
    tick();
    n_checks++;
    if (addr !== prev + 8'd1) begin
      n_fail++;
      $display("FAIL jmp_not_taken: addr=%02h want %02h", addr, prev + 8'd1);
    end
    idle();
  endtask

  task automatic test_call_ret();
    logic [7:0] exp_addr [4];
    logic [2:0] exp_sp [4];
    exp_addr = '{8'h20, 8'h30, 8'h21, 8'h06};
    exp_sp   = '{3'd1, 3'd2, 3'd1, 3'd0};
    do_reset(1);
    repeat (5) tick();
    flags = 8'b0000_0001; op = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      idle();
      case (i)
        0: begin call = 1; target = 8'h20; end
        1: begin call = 1; target = 8'h30; end
        default: ret = 1;
      endcase
      tick();
      n_checks++;
      if (addr !== exp_addr[i] || sp !== exp_sp[i]) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: addr=%02h sp=%0d want %02h sp=%0d",
                 i, addr, sp, exp_addr[i], exp_sp[i]);
      end
    end
    idle();
  endtask

  task automatic test_overflow();
    logic [7:0] prev;
    do_reset(1);
    flags = 8'b1000_0000; op = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      idle(); call = 1; target = 8'h10 + 8'(i * 16);
      prev = m_addr;
      tick();
      n_checks++;
      if (i < 4) begin
        if (addr !== target || sp !== 3'(i + 1) || ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL call_fill[%0d]: addr=%02h sp=%0d ovf=%b want %02h sp=%0d ovf=0",
                   i, addr, sp, ovf, target, i + 1);
        end
      end else if (addr !== prev + 8'd1 || sp !== 3'd4 || ovf !== 1'b1) begin
        n_fail++;
        $display("FAIL call_overflow: addr=%02h sp=%0d ovf=%b want %02h sp=4 ovf=1",
                 addr, sp, ovf, prev + 8'd1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      idle(); ret = 1;
      prev = m_addr;
      tick();
      n_checks++;
      if (addr !== m_addr || sp !== 3'(m_stack.size()) || unf !== (i == 4) || ovf !== 1'b1) begin
        n_fail++;
        $display("FAIL ret_drain[%0d]: addr=%02h sp=%0d unf=%b want %02h sp=%0d unf=%b",
                 i, addr, sp, unf, m_addr, m_stack.size(), i == 4);
      end
      if (i == 4) begin
        n_checks++;
        if (addr !== prev + 8'd1) begin
          n_fail++;
          $display("FAIL ret_underflow_addr: addr=%02h want %02h", addr, prev + 8'd1);
        end
      end
    end
    idle();
  endtask

  task automatic test_stall_priority();
    logic [7:0] hold_addr;
    logic [2:0] hold_sp;
    do_reset(1);
    flags = 8'h00; op = 4'b0011;
    call = 1; target = 8'h55;
    tick();
    hold_addr = 8'h55; hold_sp = 3'd1;
    stall = 1; target = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (addr !== hold_addr || sp !== hold_sp) begin
        n_fail++;
        $display("FAIL stall[%0d]: addr=%02h sp=%0d want %02h sp=%0d",
                 i, addr, sp, hold_addr, hold_sp);
      end
    end
    stall = 0; ret = 1; call = 1; jmp = 1; target = 8'h99;
    tick();
    n_checks++;
    if (addr !== 8'h01 || sp !== 3'd0) begin
      n_fail++;
      $display("FAIL priority_ret: addr=%02h sp=%0d want 01 sp=0", addr, sp);
    end
    idle();
  endtask

  task automatic test_wrap_reset_mid();
    do_reset(1);
    flags = 8'h04; op = 4'b1010;
    jmp = 1; target = 8'hFF;
    tick();
    idle(); call = 1; target = 8'h10;
    tick();
    n_checks++;
    if (addr !== 8'h10 || sp !== 3'd1) begin
      n_fail++;
      $display("FAIL wrap_call: addr=%02h sp=%0d want 10 sp=1", addr, sp);
    end
    idle(); tick();
    ret = 1;
    tick();
    n_checks++;
    if (addr !== 8'h00 || sp !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_ret: addr=%02h sp=%0d want 00 sp=0", addr, sp);
    end
    idle(); call = 1;
    for (int i = 0; i < 3; i++) begin
      target = 8'hA0 + 8'(i);
      tick();
    end
    n_checks++;
    if (sp !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_setup: sp=%0d want 3", sp);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    n_checks++;
    if (addr !== 8'h00 || sp !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: addr=%02h sp=%0d want 00 sp=0", addr, sp);
    end
    idle();
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 79) != 0);
      stall  = ($urandom_range(0, 4) == 0);
      ret    = ($urandom_range(0, 3) == 0);
      call   = ($urandom_range(0, 2) == 0);
      jmp    = ($urandom_range(0, 2) == 0);
      op     = 4'($urandom);
      flags  = 8'($urandom);
      target = 8'($urandom);
      tick();
      n_checks++;
      if (addr !== m_addr || sp !== 3'(m_stack.size()) || ovf !== m_ovf || unf !== m_unf) begin
        n_fail++;
        $display("FAIL random[%0d]: addr=%02h sp=%0d ovf=%b unf=%b want %02h sp=%0d ovf=%b unf=%b",
                 i, addr, sp, ovf, unf, m_addr, m_stack.size(), m_ovf, m_unf);
      end
    end
    rst_n = 1;
    idle();
  endtask

  initial begin
    rst_n = 0; stall = 0; jmp = 0; call = 0; ret = 0;
    op = '0; flags = '0; target = '0;
    m_addr = 8'h00; m_ovf = 0; m_unf = 0;
    test_reset();
    test_jump();
    test_call_ret();
    test_overflow();
    test_stall_priority();
    test_wrap_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
